// File: rtl/toggle_counting_if.sv
// Data-side bundle for the toggle counter: parallel load word, shift
// controls, serial input and the combinational toggle count.
interface toggle_counting_if #(
    parameter int n = 64,
    parameter int h = 8
);
    logic [n-1:0] par_in;
    logic         mode;
    logic         load;
    logic         D;
    logic [h-1:0] out;

    // Driver side: supplies data and controls, observes the count
    modport master (
        output par_in,
        output mode,
        output load,
        output D,
        input  out
    );

    // Counter side: consumes data and controls, produces the count
    modport slave (
        input  par_in,
        input  mode,
        input  load,
        input  D,
        output out
    );
endinterface

// File: rtl/toggle_counting.sv
// Shift register with parallel load that continuously reports how many
// adjacent bit pairs differ (a transition-density monitor). The count is
// purely combinational on the register, so it follows the new contents in
// the same cycle as the edge that produced them.
module toggle_counting #(
    parameter int n = 64,
    parameter int h = 8
) (
    input  logic              clock,
    input  logic              reset,
    toggle_counting_if.slave  bus
);

    logic [n-1:0] r_q;
    logic [n-1:0] r_d;
    logic [n-2:0] diff_d;
    logic [h-1:0] count_d;

    // Next register value: load beats shifting; otherwise shift every cycle
    always_comb begin
        r_d = r_q;
        if (bus.load) begin
            r_d = bus.par_in;
        end else if (bus.mode) begin
            r_d = {bus.D, r_q[n-1:1]};
        end else begin
            r_d = {r_q[n-2:0], bus.D};
        end
    end

    // Register state; an asserted reset wipes all data immediately
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            r_q <= r_d;
        end
    end

    // Popcount of neighbour differences; accumulating in h bits wraps
    // modulo 2^h if the output has been sized too narrow
    always_comb begin
        diff_d  = r_q[n-1:1] ^ r_q[n-2:0];
        count_d = '0;
        for (int i = 0; i < n - 1; i++) begin
            count_d = count_d + h'(diff_d[i]);
        end
    end

    assign bus.out = count_d;

endmodule

// File: tb/tb_toggle_counting.sv
// Directed bench for toggle_counting: reset (sync and async), parallel
// load, left/right shifting, a serial toggle stream against a reference
// register, load priority and mid-stream reset.
module tb_toggle_counting;

    localparam int N = 64;
    localparam int H = 8;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    logic [N-1:0] model_r;
    logic         d_sample;

    toggle_counting_if #(.n(N), .h(H)) bus ();

    toggle_counting #(.n(N), .h(H)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one rising edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [H-1:0] expected);
        checks++;
        if (bus.out !== expected) begin
            failures++;
            $display("[TB] FAIL %s: out=%0d expected=%0d at t=%0t", name, bus.out, expected, $time);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        bus.load   = 1'b1;
        bus.mode   = 1'b1;
        bus.D      = 1'b1;
        bus.par_in = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        expect_out("reset_held", 8'd0);
        tick();
        expect_out("reset_held_2", 8'd0);
        #3;
        reset    = 1'b1;
        bus.load = 1'b0;
        bus.mode = 1'b0;
        bus.D    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("reset_idle", 8'd0);
        end
        bus.load   = 1'b1;
        bus.par_in = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        bus.load = 1'b0;
        expect_out("async_pre", 8'd63);
        #3;
        reset = 1'b0;
        #1;
        expect_out("async_clear", 8'd0);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_load();
        bus.load   = 1'b1;
        bus.par_in = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        expect_out("load_alt", 8'd63);
        bus.par_in = 64'h0000_0000_FFFF_FFFF;
        tick();
        expect_out("load_half", 8'd1);
        bus.par_in = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        expect_out("load_ones", 8'd0);
        bus.load = 1'b0;
    endtask

    task automatic test_left_shift();
        reset = 1'b0;
        #2;
        reset    = 1'b1;
        bus.load = 1'b0;
        bus.mode = 1'b0;
        bus.D    = 1'b1;
        tick();
        expect_out("left_bit0", 8'd1);
        bus.D = 1'b0;
        tick();
        expect_out("left_bit1", 8'd2);
        for (int i = 0; i < 61; i++) tick();
        expect_out("left_bit62", 8'd2);
        tick();
        expect_out("left_bit63", 8'd1);
        tick();
        expect_out("left_out", 8'd0);
    endtask

    task automatic test_right_shift();
        bus.load   = 1'b1;
        bus.par_in = 64'h1;
        tick();
        expect_out("right_load1", 8'd1);
        bus.load = 1'b0;
        bus.mode = 1'b1;
        bus.D    = 1'b0;
        tick();
        expect_out("right_drop", 8'd0);
        bus.D = 1'b1;
        tick();
        expect_out("right_msb", 8'd1);
        bus.D = 1'b0;
        tick();
        expect_out("right_bit62", 8'd2);
    endtask

    task automatic test_back_to_back();
        bus.load   = 1'b1;
        bus.par_in = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        expect_out("b2b_load", 8'd63);
        bus.load = 1'b0;
        bus.mode = 1'b0;
        bus.D    = 1'b1;
        tick();
        expect_out("b2b_shift1", 8'd63);
        tick();
        expect_out("b2b_shift2", 8'd62);
    endtask

    task automatic test_stream();
        logic [H-1:0] expected;
        int           stream_fail;
        stream_fail = 0;
        bus.load   = 1'b1;
        bus.par_in = '0;
        tick();
        bus.load = 1'b0;
        bus.mode = 1'b0;
        bus.D    = 1'b0;
        model_r  = '0;
        fork
            begin
                repeat (120) begin
                    #25 bus.D = ~bus.D;
                end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    @(negedge clock);
                    #4;
                    d_sample = bus.D;
                    tick();
                    model_r  = {model_r[N-2:0], d_sample};
                    expected = H'($countones(model_r[N-1:1] ^ model_r[N-2:0]));
                    checks++;
                    if (bus.out !== expected || bus.out > 8'd63) begin
                        failures++;
                        stream_fail++;
                        if (stream_fail <= 5)
                            $display("[TB] FAIL stream[%0d]: out=%0d expected=%0d", i, bus.out, expected);
                    end
                end
            end
        join
    endtask

    task automatic test_priority_reset();
        bus.load   = 1'b1;
        bus.mode   = 1'b1;
        bus.D      = 1'b1;
        bus.par_in = 64'h5;
        tick();
        expect_out("prio_load", 8'd3);
        bus.load = 1'b0;
        bus.mode = 1'b0;
        bus.D    = 1'b1;
        tick();
        expect_out("prio_shift", 8'd3);
        #3;
        reset = 1'b0;
        #1;
        expect_out("mid_reset", 8'd0);
        #1;
        reset = 1'b1;
        tick();
        expect_out("resume_1", 8'd1);
        tick();
        expect_out("resume_3", 8'd1);
        bus.D = 1'b0;
        tick();
        expect_out("resume_6", 8'd2);
    endtask

    // Run every scenario in order, then report
    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        bus.load   = 1'b0;
        bus.mode   = 1'b0;
        bus.D      = 1'b0;
        bus.par_in = '0;
        test_reset();
        test_load();
        test_left_shift();
        test_right_shift();
        test_back_to_back();
        test_stream();
        test_priority_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
